// File: rtl/dct_block_ctrl.sv
// Block sequencer for the dct_2d_8x8 datapath: load 8 rows, wait the DCT latency, drain 8 rows.
// Optional block counter output blk_count when DCT_CTRL_STATS_EN is defined.
module dct_block_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DCT_LATENCY = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH*8-1:0]    in_row,
    output logic [DATA_WIDTH*64-1:0]   dct_data_in,
    input  logic [DATA_WIDTH*64-1:0]   dct_data_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH*8-1:0]    out_row,
    output logic                       out_last,
`ifdef DCT_CTRL_STATS_EN
    output logic [15:0]                blk_count,
`endif
    output logic                       busy
);

    localparam int unsigned ROW_W = DATA_WIDTH * 8;

    typedef enum logic [1:0] {StLoad, StWait, StDrain} state_e;

    state_e                   state_q, state_d;
    logic [2:0]               row_idx_q, row_idx_d;
    logic [7:0]               wait_cnt_q, wait_cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic [DATA_WIDTH*64-1:0] mat_q;
    logic [DATA_WIDTH*64-1:0] obuf_q;
    logic                     in_hs, out_hs, capture;

    assign in_hs  = (state_q == StLoad) && in_valid;
    assign out_hs = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        wait_cnt_d  = wait_cnt_q;
        out_valid_d = 1'b0;
        capture     = 1'b0;
        case (state_q)
            StLoad: begin
                if (in_valid) begin
                    row_idx_d = row_idx_q + 3'd1;
                    if (row_idx_q == 3'd7) begin
                        wait_cnt_d = 8'(DCT_LATENCY);
                        state_d    = StWait;
                    end
                end
            end
            StWait: begin
                if (wait_cnt_q == 8'd0) begin
                    capture = 1'b1;
                    state_d = StDrain;
                end else begin
                    wait_cnt_d = wait_cnt_q - 8'd1;
                end
            end
            StDrain: begin
                // out_valid is registered, so it rises one cycle after entering DRAIN
                out_valid_d = 1'b1;
                if (out_hs) begin
                    row_idx_d = row_idx_q + 3'd1;
                    if (row_idx_q == 3'd7) begin
                        out_valid_d = 1'b0;
                        state_d     = StLoad;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StLoad;
            row_idx_q   <= 3'd0;
            wait_cnt_q  <= 8'd0;
            out_valid_q <= 1'b0;
            mat_q       <= '0;
            obuf_q      <= '0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            wait_cnt_q  <= wait_cnt_d;
            out_valid_q <= out_valid_d;
            if (in_hs) begin
                mat_q[32'(row_idx_q)*ROW_W +: ROW_W] <= in_row;
            end
            if (capture) begin
                obuf_q <= dct_data_out;
            end
        end
    end

`ifdef DCT_CTRL_STATS_EN
    logic [15:0] blk_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_count_q <= 16'd0;
        end else if (out_hs && (row_idx_q == 3'd7)) begin
            blk_count_q <= blk_count_q + 16'd1;
        end
    end

    assign blk_count = blk_count_q;
`endif

    always_comb begin
        out_row = obuf_q[32'(row_idx_q)*ROW_W +: ROW_W];
    end

    assign dct_data_in = mat_q;
    assign in_ready    = (state_q == StLoad);
    assign busy        = (state_q != StLoad);
    assign out_valid   = out_valid_q;
    assign out_last    = out_valid_q && (row_idx_q == 3'd7);

endmodule

// File: tb/tb_dct_block_ctrl.sv
// Directed bench for dct_block_ctrl: a latency-4 instance with a pipelined DCT model and a
// latency-0 instance with a combinational model. Block counter checked when DCT_CTRL_STATS_EN.
module tb_dct_block_ctrl;

    localparam int DW  = 32;
    localparam int LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic            in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [DW*8-1:0] in_row, out_row;
    logic [DW*64-1:0] dct_data_in, dct_data_out;

    logic            in_valid0, in_ready0, out_valid0, out_ready0, out_last0, busy0;
    logic [DW*8-1:0] in_row0, out_row0;
    logic [DW*64-1:0] dct_data_in0, dct_data_out0;

`ifdef DCT_CTRL_STATS_EN
    logic [15:0] blk_count, blk_count0;
`endif

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [DW*8-1:0] row_val(input int b, input int r);
        logic [DW*8-1:0] v;
        for (int c = 0; c < 8; c++) v[c*DW +: DW] = 32'(b*1000 + r*8 + c);
        return v;
    endfunction

    function automatic logic [DW*64-1:0] mat_val(input int b);
        logic [DW*64-1:0] m;
        for (int r = 0; r < 8; r++) m[r*DW*8 +: DW*8] = row_val(b, r);
        return m;
    endfunction

    // Stand-in transform: position-dependent so any row/column mix-up is visible
    function automatic logic [DW*64-1:0] dct_f(input logic [DW*64-1:0] m);
        logic [DW*64-1:0] o;
        for (int i = 0; i < 64; i++) o[i*DW +: DW] = (m[(63-i)*DW +: DW] << 4) ^ 32'(i);
        return o;
    endfunction

    logic [DW*64-1:0] pipe [LAT];
    always_ff @(posedge clk) begin
        pipe[0] <= dct_f(dct_data_in);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign dct_data_out  = pipe[LAT-1];
    assign dct_data_out0 = dct_f(dct_data_in0);

    dct_block_ctrl #(.DATA_WIDTH(DW), .DCT_LATENCY(LAT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_row       (in_row),
        .dct_data_in  (dct_data_in),
        .dct_data_out (dct_data_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row      (out_row),
        .out_last     (out_last),
`ifdef DCT_CTRL_STATS_EN
        .blk_count    (blk_count),
`endif
        .busy         (busy)
    );

    dct_block_ctrl #(.DATA_WIDTH(DW), .DCT_LATENCY(0)) dut0 (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid0),
        .in_ready     (in_ready0),
        .in_row       (in_row0),
        .dct_data_in  (dct_data_in0),
        .dct_data_out (dct_data_out0),
        .out_valid    (out_valid0),
        .out_ready    (out_ready0),
        .out_row      (out_row0),
        .out_last     (out_last0),
`ifdef DCT_CTRL_STATS_EN
        .blk_count    (blk_count0),
`endif
        .busy         (busy0)
    );

    task automatic check_matrix(input string name, input logic [DW*64-1:0] exp);
        vectors++;
        if (dct_data_in !== exp) begin
            miscompares++;
            $display("FAIL %s: dct_data_in low word %h want %h, %0d bits differ", name,
                     dct_data_in[DW-1:0], exp[DW-1:0], $countones(dct_data_in ^ exp));
        end
    endtask

    // Returns at the negedge just after the row-7 accept edge
    task automatic feed_block(input int b, input bit gaps);
        for (int r = 0; r < 8; r++) begin
            if (gaps) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_row   = row_val(b, r);
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL feed_ready b%0d r%0d: in_ready=%b want 1", b, r, in_ready);
            end
            @(negedge clk);
        end
        in_valid = gaps;
        in_row   = '1;
    endtask

    task automatic wait_out(input int exp_n);
        int  n = 1;
        bit  rdy_seen = 1'b0;
        while (!out_valid && n < 60) begin
            if (in_ready || !busy) rdy_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        vectors++;
        if (out_valid !== 1'b1 || n != exp_n) begin
            miscompares++;
            $display("FAIL first_out_latency: out_valid=%b after %0d cycles want 1 after %0d",
                     out_valid, n, exp_n);
        end
        vectors++;
        if (rdy_seen) begin
            miscompares++;
            $display("FAIL wait_idle: in_ready/busy showed idle during WAIT want busy");
        end
    endtask

    task automatic drain_block(input int b, input int stall_row, input int stall_len);
        logic [DW*64-1:0] exp;
        logic [DW*8-1:0]  erow;
        exp = dct_f(mat_val(b));
        for (int r = 0; r < 8; r++) begin
            erow = exp[r*DW*8 +: DW*8];
            if (r == stall_row) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    vectors++;
                    if (out_valid !== 1'b1 || out_row !== erow || out_last !== (r == 7) ||
                        in_ready !== 1'b0) begin
                        miscompares++;
                        $display("FAIL stall r%0d s%0d: valid=%b last=%b in_ready=%b row=%h want 1/%b/0 row=%h",
                                 r, s, out_valid, out_last, in_ready, out_row, r == 7, erow);
                    end
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            vectors++;
            if (out_valid !== 1'b1 || out_row !== erow) begin
                miscompares++;
                $display("FAIL out_row b%0d r%0d: valid=%b row=%h want 1 row=%h",
                         b, r, out_valid, out_row, erow);
            end
            vectors++;
            if (out_last !== (r == 7)) begin
                miscompares++;
                $display("FAIL out_last b%0d r%0d: %b want %b", b, r, out_last, r == 7);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL post_drain: in_ready=%b out_valid=%b busy=%b want 1 0 0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic check_count(input logic [15:0] got, input logic [15:0] want);
`ifdef DCT_CTRL_STATS_EN
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL blk_count: %0d want %0d", got, want);
        end
`else
        if (got !== want) begin end
`endif
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_valid = 1'b0; in_row = '0; out_ready = 1'b1;
        in_valid0 = 1'b0; in_row0 = '0; out_ready0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b out_last=%b want 1 0 0 0",
                     in_ready, out_valid, busy, out_last);
        end
        vectors++;
        if (out_row !== '0) begin
            miscompares++;
            $display("FAIL reset_out_row: %h want 0", out_row);
        end
        check_matrix("reset_dct_in", '0);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_block();
        feed_block(0, 1'b0);
        check_matrix("single_dct_in", mat_val(0));
        wait_out(LAT + 3);
        drain_block(0, -1, 0);
        check_matrix("single_hold", mat_val(0));
`ifdef DCT_CTRL_STATS_EN
        check_count(blk_count, 16'd1);
`endif
    endtask

    task automatic test_backpressure();
        feed_block(1, 1'b0);
        wait_out(LAT + 3);
        drain_block(1, 3, 10);
`ifdef DCT_CTRL_STATS_EN
        check_count(blk_count, 16'd2);
`endif
    endtask

    task automatic test_gaps();
        feed_block(2, 1'b1);
        check_matrix("gaps_dct_in_wait", mat_val(2));
        wait_out(LAT + 3);
        drain_block(2, 5, 2);
        check_matrix("gaps_dct_in_after", mat_val(2));
    endtask

    task automatic test_reset_mid_block();
        for (int r = 0; r < 5; r++) begin
            in_valid = 1'b1;
            in_row   = row_val(7, r);
            @(negedge clk);
        end
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_async: in_ready=%b busy=%b want 1 0", in_ready, busy);
        end
        check_matrix("mid_reset_dct_in", '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        feed_block(8, 1'b0);
        check_matrix("mid_reset_new_block", mat_val(8));
        wait_out(LAT + 3);
        drain_block(8, -1, 0);
`ifdef DCT_CTRL_STATS_EN
        check_count(blk_count, 16'd1);
`endif
    endtask

    task automatic test_latency0();
        logic [DW*64-1:0] exp;
        int n;
        exp = dct_f(mat_val(20));
        for (int r = 0; r < 8; r++) begin
            in_valid0 = 1'b1;
            in_row0   = row_val(20, r);
            @(negedge clk);
        end
        in_valid0 = 1'b0;
        n = 1;
        while (!out_valid0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (out_valid0 !== 1'b1 || n != 3) begin
            miscompares++;
            $display("FAIL lat0_first_out: out_valid=%b after %0d cycles want 1 after 3",
                     out_valid0, n);
        end
        for (int r = 0; r < 8; r++) begin
            vectors++;
            if (out_valid0 !== 1'b1 || out_row0 !== exp[r*DW*8 +: DW*8] ||
                out_last0 !== (r == 7)) begin
                miscompares++;
                $display("FAIL lat0_row r%0d: valid=%b last=%b row=%h want 1 %b row=%h",
                         r, out_valid0, out_last0, out_row0, r == 7, exp[r*DW*8 +: DW*8]);
            end
            @(negedge clk);
        end
        vectors++;
        if (in_ready0 !== 1'b1 || busy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL lat0_post: in_ready=%b busy=%b want 1 0", in_ready0, busy0);
        end
`ifdef DCT_CTRL_STATS_EN
        check_count(blk_count0, 16'd1);
`endif
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_backpressure();
        test_gaps();
        test_reset_mid_block();
        test_latency0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
